// File: rtl/ahb_matrix_input_stage.sv
// AHB matrix per-master input stage: pass-through, or hold-and-replay when the target output stage is busy.
// Optional hold timeout with a two-cycle ERROR abort: define MATRIX_INSTAGE_HOLD_TIMEOUT_EN.
module ahb_matrix_input_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HREADYS,
    input  logic              active_dec,
    input  logic              readyout_dec,
    input  logic [1:0]        resp_dec,
    output logic              sel_dec,
    output logic [ADDR_W-1:0] addr_dec,
    output logic [1:0]        trans_dec,
    output logic              write_dec,
    output logic [2:0]        size_dec,
    output logic [2:0]        burst_dec,
    output logic [3:0]        prot_dec,
    output logic              ready_dec,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS,
    output logic              held_tran
);
    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {ST_PASS, ST_HOLD, ST_ERR1, ST_ERR2} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [2:0]        r_size;
    logic [2:0]        r_burst;
    logic [3:0]        r_prot;
    logic              w_xfer;
    logic              w_load;

    assign w_xfer = HSELS & HTRANSS[1] & HREADYS;
    // Loading only from PASS guarantees a transfer can never be replayed twice.
    assign w_load = (r_state == ST_PASS) & w_xfer & ~active_dec;

`ifdef MATRIX_INSTAGE_HOLD_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       w_timeout;

    assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_cnt <= '0;
        else if (w_load)
            r_cnt <= '0;
        else if (r_state == ST_HOLD && r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
    end
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_state <= ST_PASS;
        else
            r_state <= w_next;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
        end else if (w_load) begin
            r_addr  <= HADDRS;
            r_write <= HWRITES;
            r_size  <= HSIZES;
            r_burst <= HBURSTS;
            r_prot  <= HPROTS;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_PASS: if (w_load) w_next = ST_HOLD;
            ST_HOLD: begin
                if (active_dec)
                    w_next = ST_PASS;
`ifdef MATRIX_INSTAGE_HOLD_TIMEOUT_EN
                else if (w_timeout)
                    w_next = ST_ERR1;
`endif
            end
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_PASS;
        endcase
    end

    always_comb begin
        sel_dec    = HSELS;
        addr_dec   = HADDRS;
        trans_dec  = HTRANSS;
        write_dec  = HWRITES;
        size_dec   = HSIZES;
        burst_dec  = HBURSTS;
        prot_dec   = HPROTS;
        ready_dec  = HREADYS;
        HREADYOUTS = readyout_dec;
        HRESPS     = resp_dec;
        held_tran  = 1'b0;
        case (r_state)
            ST_HOLD: begin
                // Replay as NONSEQ so the re-arbitrated beat starts a fresh burst downstream.
                sel_dec    = 1'b1;
                addr_dec   = r_addr;
                trans_dec  = TR_NONSEQ;
                write_dec  = r_write;
                size_dec   = r_size;
                burst_dec  = r_burst;
                prot_dec   = r_prot;
                ready_dec  = 1'b1;
                HREADYOUTS = 1'b0;
                HRESPS     = RESP_OKAY;
                held_tran  = 1'b1;
            end
            ST_ERR1: begin
                sel_dec    = 1'b0;
                trans_dec  = TR_IDLE;
                HREADYOUTS = 1'b0;
                HRESPS     = RESP_ERROR;
            end
            ST_ERR2: begin
                HREADYOUTS = 1'b1;
                HRESPS     = RESP_ERROR;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ahb_matrix_input_stage.sv
// Directed + random bench for ahb_matrix_input_stage against a queue-based transaction model.
module tb_ahb_matrix_input_stage;
    localparam int AW = 32;
`ifdef MATRIX_INSTAGE_HOLD_TIMEOUT_EN
    localparam int TO  = 4;
    localparam bit TOE = 1'b1;
`else
    localparam int TO  = 255;
    localparam bit TOE = 1'b0;
`endif

    logic          HCLK, HRESETn, HSELS, HWRITES, HREADYS;
    logic [AW-1:0] HADDRS, addr_dec;
    logic [1:0]    HTRANSS, resp_dec, trans_dec, HRESPS;
    logic [2:0]    HSIZES, HBURSTS, size_dec, burst_dec;
    logic [3:0]    HPROTS, prot_dec;
    logic          active_dec, readyout_dec, sel_dec, write_dec, ready_dec, HREADYOUTS, held_tran;

    // The fabric loops HREADYOUTS back as HREADY.
    assign HREADYS = HREADYOUTS;

    ahb_matrix_input_stage #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
        .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HREADYS(HREADYS),
        .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
        .sel_dec(sel_dec), .addr_dec(addr_dec), .trans_dec(trans_dec), .write_dec(write_dec),
        .size_dec(size_dec), .burst_dec(burst_dec), .prot_dec(prot_dec), .ready_dec(ready_dec),
        .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .held_tran(held_tran)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
    } xfer_t;

    xfer_t held_q[$];   // pending transfer not yet accepted (0 or 1 entries)
    int    err_ph;      // 0 none, 1/2 = first/second cycle of the ERROR abort
    int    hold_age;    // completed hold cycles of the pending transfer
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [AW-1:0] a, input logic [1:0] tr,
                         input logic act, input logic rdy, input logic [1:0] rsp);
        HSELS = sel; HADDRS = a; HTRANSS = tr;
        active_dec = act; readyout_dec = rdy; resp_dec = rsp;
        HWRITES = 1'($urandom); HSIZES = 3'($urandom); HBURSTS = 3'($urandom); HPROTS = 4'($urandom);
    endtask

    function automatic logic exp_ready();
        if (err_ph == 1) return 1'b0;
        if (err_ph == 2) return 1'b1;
        if (held_q.size() != 0) return 1'b0;
        return readyout_dec;
    endfunction

    task automatic check_model();
        logic          e_sel, e_wr;
        logic [AW-1:0] e_addr;
        logic [1:0]    e_tr, e_rsp;
        logic [2:0]    e_sz, e_bu;
        logic [3:0]    e_pr;
        if (err_ph == 1) begin
            chk("err1_sel", sel_dec, 0); chk("err1_trans", trans_dec, 0);
            chk("err1_hready", HREADYOUTS, 0); chk("err1_resp", HRESPS, 1); chk("err1_held", held_tran, 0);
            return;
        end
        if (err_ph == 2) begin
            chk("err2_hready", HREADYOUTS, 1); chk("err2_resp", HRESPS, 1); chk("err2_held", held_tran, 0);
            chk("err2_addr", addr_dec, HADDRS); chk("err2_sel", sel_dec, HSELS);
            return;
        end
        if (held_q.size() != 0) begin
            e_sel = 1'b1; e_addr = held_q[0].addr; e_tr = 2'b10; e_wr = held_q[0].wr;
            e_sz = held_q[0].size; e_bu = held_q[0].burst; e_pr = held_q[0].prot; e_rsp = 2'b00;
        end else begin
            e_sel = HSELS; e_addr = HADDRS; e_tr = HTRANSS; e_wr = HWRITES;
            e_sz = HSIZES; e_bu = HBURSTS; e_pr = HPROTS; e_rsp = resp_dec;
        end
        chk("sel_dec", sel_dec, e_sel);
        chk("addr_dec", addr_dec, e_addr);
        chk("trans_dec", trans_dec, e_tr);
        chk("ctrl_dec", {write_dec, size_dec, burst_dec, prot_dec}, {e_wr, e_sz, e_bu, e_pr});
        chk("ready_dec", ready_dec, (held_q.size() != 0) ? 1'b1 : exp_ready());
        chk("HREADYOUTS", HREADYOUTS, exp_ready());
        chk("HRESPS", HRESPS, e_rsp);
        chk("held_tran", held_tran, held_q.size() != 0);
    endtask

    // One bus cycle: compare against the model, then advance the model at the clock edge.
    task automatic tick();
        logic  x;
        xfer_t t;
        #1;
        check_model();
        x = HSELS & HTRANSS[1] & exp_ready();
        @(posedge HCLK);
        if (err_ph == 1) err_ph = 2;
        else if (err_ph == 2) err_ph = 0;
        else if (held_q.size() != 0) begin
            if (active_dec) void'(held_q.pop_front());
            else if (TOE && hold_age == TO) begin
                void'(held_q.pop_front());
                err_ph = 1;
            end else hold_age++;
        end else if (x && !active_dec) begin
            t.addr = HADDRS; t.wr = HWRITES; t.size = HSIZES; t.burst = HBURSTS; t.prot = HPROTS;
            held_q.push_back(t);
            hold_age = 0;
        end
        #1;
    endtask

    initial begin
        err_ph = 0; hold_age = 0;
        HRESETn = 1'b0;
        drive(0, '0, 2'b00, 0, 1, 2'b00);
        #12;
        chk("rst_held", held_tran, 0); chk("rst_hready", HREADYOUTS, 1); chk("rst_resp", HRESPS, 0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // pass-through
        drive(1, 32'h40, 2'b10, 1, 1, 2'b00);
        #1; chk("pt_addr", addr_dec, 32'h40); chk("pt_held", held_tran, 0); chk("pt_hready", HREADYOUTS, 1);
        tick();

        // hold and replay: accepted on the third held cycle
        drive(1, 32'h100, 2'b10, 0, 1, 2'b00);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h100, 2'b10, (k == 2), 1, 2'b00);
            #1;
            chk("hr_held", held_tran, 1); chk("hr_addr", addr_dec, 32'h100);
            chk("hr_trans", trans_dec, 2'b10); chk("hr_hready", HREADYOUTS, 0);
            tick();
        end
        drive(0, 32'h0, 2'b00, 1, 0, 2'b00);
        #1; chk("dp_wait", HREADYOUTS, 0); chk("dp_held", held_tran, 0);
        tick();
        drive(0, 32'h0, 2'b00, 1, 1, 2'b00);
        #1; chk("dp_done", HREADYOUTS, 1);
        tick();

        // IDLE and deselected transfers never held
        drive(1, 32'h180, 2'b00, 0, 1, 2'b00); tick();
        drive(0, 32'h184, 2'b10, 0, 1, 2'b00); tick();
        #1; chk("idle_held", held_tran, 0); chk("idle_hready", HREADYOUTS, 1);

        // back-to-back: SEQ held behind a completing write data phase
        drive(1, 32'h200, 2'b10, 1, 1, 2'b00); HWRITES = 1'b1; tick();
        drive(1, 32'h204, 2'b11, 0, 1, 2'b00);
        #1; chk("b2b_prior_ready", HREADYOUTS, 1); chk("b2b_prior_resp", HRESPS, 0);
        tick();
        #1; chk("b2b_trans", trans_dec, 2'b10); chk("b2b_addr", addr_dec, 32'h204);
        drive(1, 32'h204, 2'b11, 1, 1, 2'b00); tick();
        drive(0, 32'h0, 2'b00, 1, 1, 2'b00); tick();

        // reset asserted mid-hold
        drive(1, 32'h300, 2'b10, 0, 1, 2'b00); tick();
        #1; chk("rh_held_pre", held_tran, 1);
        HRESETn = 1'b0;
        held_q.delete(); err_ph = 0;
        #1; chk("rh_held", held_tran, 0); chk("rh_hready", HREADYOUTS, 1); chk("rh_resp", HRESPS, 0);
        @(posedge HCLK); #2;
        HRESETn = 1'b1;
        drive(0, 32'h0, 2'b00, 1, 1, 2'b00);
        #1; chk("rh_no_replay", sel_dec, 0);
        tick();

`ifdef MATRIX_INSTAGE_HOLD_TIMEOUT_EN
        drive(1, 32'h500, 2'b10, 0, 1, 2'b00); tick();
        for (int k = 0; k < TO + 1; k++) begin
            drive(0, 32'h0, 2'b00, 0, 1, 2'b00);
            #1; chk("to_held", held_tran, 1);
            tick();
        end
        #1; chk("to_err1_hready", HREADYOUTS, 0); chk("to_err1_resp", HRESPS, 2'b01);
        tick();
        #1; chk("to_err2_hready", HREADYOUTS, 1); chk("to_err2_resp", HRESPS, 2'b01);
        tick();
        #1; chk("to_pass_held", held_tran, 0); chk("to_pass_resp", HRESPS, 0);
        tick();
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 4) != 0, {$urandom} & 32'hFFFF_FFFC, 2'($urandom),
                  ($urandom % 5) < 3, ($urandom % 4) != 0, (($urandom % 6) == 0) ? 2'b01 : 2'b00);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
